lbp_ctrl: RTL and testbench
===========================

LBP_CTRL -- requirements
Module: lbp_ctrl

Interface
REQ-001 Param IMG_W, default 128, image width and height in pixels.
REQ-002 Param ADDR_W, default 14, pixel address width (log2(IMG_W*IMG_W)).
REQ-003 One clock; reset is asynchronous and active-high. Ports are clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 gray_ready  in  1  gray memory available; low pauses fetching.
REQ-007 gray_req  out  1  gray read request; gray_data is valid at the rising edge ending this cycle.
REQ-008 gray_addr  out  ADDR_W  gray read address, row*IMG_W+col.
REQ-009 win_ld  out  1  datapath loads gray_data into window slot win_sel at this rising edge.
REQ-010 win_sel  out  4  window slot 0..8, row-major, 0=top-left, 4=centre.
REQ-011 win_shift  out  1  datapath shifts window columns left (slots 0<-1<-2, 3<-4<-5, 6<-7<-8) at this rising edge.
REQ-012 lbp_valid  out  1  one-cycle write strobe for lbp_data.
REQ-013 lbp_addr  out  ADDR_W  result address, centre pixel r*IMG_W+c.
REQ-014 finish  out  1  frame complete; held high until reset.

Function
REQ-015 States: IDLE, FILL, SHIFT, WRITE, DONE; all outputs registered.
REQ-016 Interior pixels only: r and c each run 1..IMG_W-2, row-major; border pixels are never written.
REQ-017 IDLE -> FILL (r=1, c=1) on the first cycle gray_ready=1.
REQ-018 FILL: 9 cycles, gray_req=win_ld=1, win_sel k=0..8, gray_addr=(r-1+k/3)*IMG_W+(c-1+k%3); then -> WRITE.
REQ-019 SHIFT: 3 cycles, gray_req=win_ld=1, win_sel 2,5,8, gray_addr=(r-1+j)*IMG_W+(c+1) for j=0..2; then -> WRITE.
REQ-020 WRITE: 1 cycle, lbp_valid=1, lbp_addr=r*IMG_W+c; gray_req=0.
REQ-021 WRITE exit: c<IMG_W-2 -> SHIFT with c+1 and win_shift=1 in this WRITE cycle; c=IMG_W-2 and r<IMG_W-2 -> FILL with r+1, c=1, win_shift=0; else -> DONE.
REQ-022 DONE: finish=1, gray_req=0, lbp_valid=0; the block stays in DONE.
REQ-023 gray_ready=0 in FILL/SHIFT: gray_req=win_ld=0, and fetch index, r and c freeze; fetch resumes at the same index once gray_ready=1. WRITE does not pause.
REQ-024 win_shift and win_ld are never asserted in the same cycle; lbp_valid and win_ld are never asserted in the same cycle.
REQ-025 Uninterrupted frame: 1 IDLE cycle, then (IMG_W-2)*(10+(IMG_W-3)*4) cycles (64260 at IMG_W=128), then finish.
REQ-026 Address arithmetic is done at ADDR_W bits; no wrap occurs for legal r and c.

Reset
REQ-027 Reset at any time, including mid-frame, forces IDLE, r=c=1, fetch index 0, and all outputs 0.
REQ-028 After reset is released, the block waits for gray_ready and restarts the frame from pixel (1,1).

Structure
REQ-029 Package lbp_pkg holds IMG_W, ADDR_W, the state enum, and the slot-index constants.
REQ-030 One sub-module, lbp_addr_gen: combinational gray_addr and lbp_addr from r, c and fetch index.

Verification
REQ-031 Start: reset, then gray_ready=1 -> gray_addr 0,1,2,128,129,130,256,257,258 with win_sel 0..8, then lbp_valid with lbp_addr=129.
REQ-032 Shift: after lbp_addr=129 -> win_shift=1 in that WRITE cycle, then gray_addr 3,131,259 with win_sel 2,5,8, then lbp_addr=130.
REQ-033 Row end: after lbp_addr=254 -> win_shift=0, next FILL gray_addr 128,129,130,...,386, then lbp_addr=257.
REQ-034 Completion: last lbp_addr=16254; finish=1 on the next cycle, 64260 cycles after the first FILL cycle; no further gray_req or lbp_valid.
REQ-035 Pause: gray_ready=0 for 5 cycles during the FILL fetch of slot 4 -> no gray_req for 5 cycles, then resume at gray_addr 129, slot 4.
REQ-036 Reset mid-frame at lbp_addr=5000 -> all outputs 0; on restart with gray_ready=1, gray_addr 0 is issued again.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and window-slot helpers for the LBP fetch/write controller.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHIFT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SLOT_TL     = 4'd0;
    localparam logic [3:0] SLOT_CENTRE = 4'd4;
    localparam logic [3:0] SLOT_BR     = 4'd8;
    localparam logic [3:0] SLOT_RCOL   = 4'd2;
    localparam logic [3:0] FILL_CNT    = 4'd9;
    localparam logic [3:0] SHIFT_CNT   = 4'd3;

    // A shift refills only the right-hand column: slots 2, 5, 8.
    function automatic logic [3:0] slot_of(input logic shift, input logic [3:0] idx);
        slot_of = shift ? (SLOT_RCOL + 4'd3 * idx) : idx;
    endfunction

endpackage

// File: rtl/lbp_addr_gen.sv
// Combinational address generation: window fetch address and result address for centre (r, c).
module lbp_addr_gen #(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] i_row,
    input  logic [ADDR_W-1:0] i_col,
    input  logic [3:0]        i_idx,
    input  logic              i_shift,
    output logic [ADDR_W-1:0] o_gray_addr,
    output logic [ADDR_W-1:0] o_lbp_addr
);

    localparam logic [ADDR_W-1:0] W_IMG = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] w_row_off;
    logic [ADDR_W-1:0] w_col_off;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;

    always_comb begin
        w_row_off = '0;
        w_col_off = '0;
        case (i_idx)
            4'd0:    begin w_row_off = ADDR_W'(0); w_col_off = ADDR_W'(0); end
            4'd1:    begin w_row_off = ADDR_W'(0); w_col_off = ADDR_W'(1); end
            4'd2:    begin w_row_off = ADDR_W'(0); w_col_off = ADDR_W'(2); end
            4'd3:    begin w_row_off = ADDR_W'(1); w_col_off = ADDR_W'(0); end
            4'd4:    begin w_row_off = ADDR_W'(1); w_col_off = ADDR_W'(1); end
            4'd5:    begin w_row_off = ADDR_W'(1); w_col_off = ADDR_W'(2); end
            4'd6:    begin w_row_off = ADDR_W'(2); w_col_off = ADDR_W'(0); end
            4'd7:    begin w_row_off = ADDR_W'(2); w_col_off = ADDR_W'(1); end
            4'd8:    begin w_row_off = ADDR_W'(2); w_col_off = ADDR_W'(2); end
            default: begin w_row_off = '0;         w_col_off = '0;         end
        endcase

        // In shift mode the index selects the row of the new right column.
        if (i_shift) begin
            w_row = i_row - W_ONE + {{(ADDR_W-4){1'b0}}, i_idx};
            w_col = i_col + W_ONE;
        end else begin
            w_row = i_row - W_ONE + w_row_off;
            w_col = i_col - W_ONE + w_col_off;
        end

        o_gray_addr = w_row * W_IMG + w_col;
        o_lbp_addr  = i_row * W_IMG + i_col;
    end

endmodule

// File: rtl/lbp_ctrl.sv
// LBP frame controller: fetches 3x3 windows from gray memory and strobes one result per interior pixel.
module lbp_ctrl #(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              win_ld,
    output logic [3:0]        win_sel,
    output logic              win_shift,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              finish
);

    import lbp_pkg::*;

    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] W_ONE  = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [3:0]        r_idx;
    logic              r_nxt_shift;
    logic              r_last;

    logic              w_shift_mode;
    logic [3:0]        w_cnt;
    logic [3:0]        w_slot;
    logic [ADDR_W-1:0] w_gray_addr;
    logic [ADDR_W-1:0] w_lbp_addr;

    // r_row/r_col advance on entry to WRITE, so during WRITE they already name the next pixel.
    assign w_shift_mode = (r_state == ST_SHIFT) || ((r_state == ST_WRITE) && r_nxt_shift);
    assign w_cnt        = (r_state == ST_SHIFT) ? SHIFT_CNT : FILL_CNT;
    assign w_slot       = slot_of(w_shift_mode, r_idx);

    lbp_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_row       (r_row),
        .i_col       (r_col),
        .i_idx       (r_idx),
        .i_shift     (w_shift_mode),
        .o_gray_addr (w_gray_addr),
        .o_lbp_addr  (w_lbp_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_row       <= W_ONE;
            r_col       <= W_ONE;
            r_idx       <= '0;
            r_nxt_shift <= 1'b0;
            r_last      <= 1'b0;
            gray_req    <= 1'b0;
            gray_addr   <= '0;
            win_ld      <= 1'b0;
            win_sel     <= '0;
            win_shift   <= 1'b0;
            lbp_valid   <= 1'b0;
            lbp_addr    <= '0;
            finish      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (gray_ready) begin
                        r_state   <= ST_FILL;
                        gray_req  <= 1'b1;
                        win_ld    <= 1'b1;
                        win_sel   <= w_slot;
                        gray_addr <= w_gray_addr;
                        r_idx     <= r_idx + 4'd1;
                    end
                end

                ST_FILL, ST_SHIFT: begin
                    if (r_idx == w_cnt) begin
                        r_state   <= ST_WRITE;
                        gray_req  <= 1'b0;
                        win_ld    <= 1'b0;
                        lbp_valid <= 1'b1;
                        lbp_addr  <= w_lbp_addr;
                        r_idx     <= '0;
                        if (r_col < W_LAST) begin
                            r_col       <= r_col + W_ONE;
                            r_nxt_shift <= 1'b1;
                            win_shift   <= 1'b1;
                        end else if (r_row < W_LAST) begin
                            r_row       <= r_row + W_ONE;
                            r_col       <= W_ONE;
                            r_nxt_shift <= 1'b0;
                        end else begin
                            r_last <= 1'b1;
                        end
                    end else if (gray_ready) begin
                        gray_req  <= 1'b1;
                        win_ld    <= 1'b1;
                        win_sel   <= w_slot;
                        gray_addr <= w_gray_addr;
                        r_idx     <= r_idx + 4'd1;
                    end else begin
                        gray_req <= 1'b0;
                        win_ld   <= 1'b0;
                    end
                end

                ST_WRITE: begin
                    lbp_valid <= 1'b0;
                    win_shift <= 1'b0;
                    if (r_last) begin
                        r_state <= ST_DONE;
                        finish  <= 1'b1;
                    end else begin
                        r_state <= r_nxt_shift ? ST_SHIFT : ST_FILL;
                        if (gray_ready) begin
                            gray_req  <= 1'b1;
                            win_ld    <= 1'b1;
                            win_sel   <= w_slot;
                            gray_addr <= w_gray_addr;
                            r_idx     <= r_idx + 4'd1;
                        end
                    end
                end

                ST_DONE: begin
                    finish <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_ctrl.sv
// Scoreboard bench for lbp_ctrl: expected fetch/write events are queued per frame and matched as they appear.
module tb_lbp_ctrl;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              gray_ready = 1'b0;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              win_ld;
    logic [3:0]        win_sel;
    logic              win_shift;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic              finish;

    lbp_ctrl #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .win_ld     (win_ld),
        .win_sel    (win_sel),
        .win_shift  (win_shift),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          first_fill_cyc = -1;
    logic        mon_en = 1'b0;
    logic [63:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [63:0] ev_fetch(input int sel, input int addr);
        logic [21:0] v;
        v = {1'b1, 1'b0, 1'b1, 1'b0, 4'(sel), 14'(addr)};
        return {42'd0, v};
    endfunction

    function automatic logic [63:0] ev_write(input logic shift, input int addr);
        logic [21:0] v;
        v = {1'b0, 1'b1, 1'b0, shift, 4'd0, 14'(addr)};
        return {42'd0, v};
    endfunction

    function automatic logic [63:0] all_outputs();
        return {27'd0, gray_req, gray_addr, win_ld, win_sel, win_shift, lbp_valid, lbp_addr, finish};
    endfunction

    task automatic push_frame();
        for (int r = 1; r <= IMG_W - 2; r++) begin
            for (int c = 1; c <= IMG_W - 2; c++) begin
                if (c == 1) begin
                    for (int k = 0; k < 9; k++)
                        sb.push_back(ev_fetch(k, (r - 1 + k / 3) * IMG_W + (c - 1 + k % 3)));
                end else begin
                    for (int j = 0; j < 3; j++)
                        sb.push_back(ev_fetch(2 + 3 * j, (r - 1 + j) * IMG_W + (c + 1)));
                end
                sb.push_back(ev_write(c < IMG_W - 2, r * IMG_W + c));
            end
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] got;
        if (!reset && mon_en && (gray_req || lbp_valid)) begin
            got = {42'd0, gray_req, lbp_valid, win_ld, win_shift,
                   gray_req ? win_sel : 4'd0, gray_req ? gray_addr : lbp_addr};
            if (gray_req && first_fill_cyc < 0) first_fill_cyc = cyc;
            if (sb.size() == 0) check("sb_extra_event", got, 64'd0);
            else check("sb_event", got, sb.pop_front());
        end
    end

    initial begin
        int   gap;
        int   fin_cyc;
        logic found;
        logic bad;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);

        // IDLE must wait while the memory is not ready.
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_wait", all_outputs(), 64'd0);

        // Frame A: pause during slot 4 fetch, then reset mid-frame.
        push_frame();
        mon_en = 1'b1;
        gray_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gray_req && win_sel == 4'd3) begin found = 1'b1; break; end
        end
        check("slot3_seen", found, 1'b1);
        gray_ready = 1'b0;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gray_req) break;
            gap++;
            if (gap == 5) gray_ready = 1'b1;
        end
        gray_ready = 1'b1;
        check("pause_gap", gap, 5);
        check("resume_fetch", {gray_req, win_sel, gray_addr}, {1'b1, 4'd4, 14'd129});

        found = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (lbp_valid && lbp_addr == 14'd5000) begin found = 1'b1; break; end
        end
        check("reach_5000", found, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", all_outputs(), 64'd0);
        sb.delete();
        first_fill_cyc = -1;

        // Frame B: uninterrupted, restarting from pixel (1,1).
        push_frame();
        @(negedge clk);
        reset = 1'b0;
        found = 1'b0;
        fin_cyc = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (finish) begin found = 1'b1; fin_cyc = cyc; break; end
        end
        check("finish_seen", found, 1'b1);
        check("frame_cycles", 64'(fin_cyc - first_fill_cyc), 64'd64260);

        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gray_req || lbp_valid || !finish) bad = 1'b1;
        end
        check("done_quiet", bad, 1'b0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
